// File: rtl/pipe_scheduler.sv
// Stall/flush scheduler for a pipeline sharing one memory port between fetch and data.
// Optional performance counters are enabled with the PIPE_SCHED_PERF_EN macro.
module pipe_scheduler #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_ready,
  input  logic             load_use,
  input  logic             branch_taken,
  input  logic             halt_req,
  input  logic             resume,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             mem_sel,
  output logic [1:0]       state
`ifdef PIPE_SCHED_PERF_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    DATA  = 2'b01,
    HALT  = 2'b10
  } state_t;

  state_t state_q, state_d;
  logic   advance;

  if (CNT_W == 0) begin : g_bad_cnt_w
    $error("pipe_scheduler: CNT_W must be nonzero");
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  assign state = state_q;

  // Outputs are forced low while rst is high, even though they are otherwise combinational.
  always_comb begin
    state_d    = state_q;
    advance    = 1'b0;
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    idex_en    = 1'b0;
    exmem_en   = 1'b0;
    memwb_en   = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    mem_sel    = 1'b0;
    if (!rst) begin
      unique case (state_q)
        FETCH: begin
          if (mem_ready) begin
            if (halt_req) begin
              state_d = HALT;
            end else begin
              state_d  = DATA;
              advance  = 1'b1;
              pc_en    = 1'b1;
              ifid_en  = 1'b1;
              idex_en  = 1'b1;
              exmem_en = 1'b1;
              memwb_en = 1'b1;
              // A taken branch squashes the dependent instruction, so it wins over load-use.
              if (branch_taken) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
              end else if (load_use) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
              end
            end
          end
        end
        DATA: begin
          mem_sel = 1'b1;
          if (mem_ready) state_d = FETCH;
        end
        HALT: begin
          if (resume) state_d = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
  end

`ifdef PIPE_SCHED_PERF_EN
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  always_comb begin
    cycle_d = cycle_q;
    stall_d = stall_q;
    flush_d = flush_q;
    if (state_q != HALT)                          cycle_d = cycle_q + 1'b1;
    if (advance && load_use && !branch_taken)     stall_d = stall_q + 1'b1;
    if (advance && branch_taken)                  flush_d = flush_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_q <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      cycle_q <= cycle_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign cycle_cnt = cycle_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`endif

endmodule

// File: tb/tb_pipe_scheduler.sv
// Scoreboard bench for pipe_scheduler: directed vectors push hand-computed expectations,
// a negedge monitor pops and compares. Counter checks are active with PIPE_SCHED_PERF_EN.
module tb_pipe_scheduler;

  localparam logic [1:0] SF = 2'b00;
  localparam logic [1:0] SD = 2'b01;
  localparam logic [1:0] SH = 2'b10;
  // {pc,ifid,idex,exmem,memwb,ifid_flush,idex_flush,mem_sel}
  localparam logic [7:0] O_ADV  = 8'b1111_1000;
  localparam logic [7:0] O_LU   = 8'b0011_1010;
  localparam logic [7:0] O_BR   = 8'b1111_1110;
  localparam logic [7:0] O_DATA = 8'b0000_0001;
  localparam logic [7:0] O_NONE = 8'b0000_0000;

  logic clk, rst, mem_ready, load_use, branch_taken, halt_req, resume;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, mem_sel;
  logic [1:0] state;
`ifdef PIPE_SCHED_PERF_EN
  logic [31:0] cycle_cnt, stall_cnt, flush_cnt;
`endif

  pipe_scheduler #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .mem_ready(mem_ready), .load_use(load_use),
    .branch_taken(branch_taken), .halt_req(halt_req), .resume(resume),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .mem_sel(mem_sel), .state(state)
`ifdef PIPE_SCHED_PERF_EN
    , .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  typedef struct {
    int          idx;
    logic [1:0]  st;
    logic [7:0]  o;
    logic [31:0] cyc;
    logic [31:0] stl;
    logic [31:0] fl;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_push   = 0;
  int   n_pop    = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // Monitor: outputs are sampled mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_pop++;
      chk("state", e.idx, {30'd0, state}, {30'd0, e.st});
      chk("outputs", e.idx,
          {24'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, mem_sel},
          {24'd0, e.o});
`ifdef PIPE_SCHED_PERF_EN
      chk("cycle_cnt", e.idx, cycle_cnt, e.cyc);
      chk("stall_cnt", e.idx, stall_cnt, e.stl);
      chk("flush_cnt", e.idx, flush_cnt, e.fl);
`endif
    end
  end

  task automatic vec(input bit r, input bit mr, input bit lu, input bit bt, input bit hr, input bit rs,
                     input logic [1:0] es, input logic [7:0] eo, input int ec, input int est, input int efl);
    exp_t x;
    @(posedge clk);
    #1;
    rst = r; mem_ready = mr; load_use = lu; branch_taken = bt; halt_req = hr; resume = rs;
    x.idx = n_push; x.st = es; x.o = eo;
    x.cyc = ec; x.stl = est; x.fl = efl;
    sb.push_back(x);
    n_push++;
  endtask

  initial begin
    rst = 1'b1; mem_ready = 1'b0; load_use = 1'b0; branch_taken = 1'b0; halt_req = 1'b0; resume = 1'b0;
    //   rst mr lu bt hr rs  state  outputs  cyc stl fl
    vec(1, 0, 0, 0, 0, 0, SF, O_NONE,  0, 0, 0);
    vec(0, 1, 0, 0, 0, 0, SF, O_ADV,   0, 0, 0);
    vec(0, 1, 0, 0, 0, 0, SD, O_DATA,  1, 0, 0);
    vec(0, 1, 0, 0, 0, 0, SF, O_ADV,   2, 0, 0);
    vec(0, 1, 0, 0, 0, 0, SD, O_DATA,  3, 0, 0);
    vec(0, 1, 0, 0, 0, 0, SF, O_ADV,   4, 0, 0);
    vec(0, 1, 0, 0, 0, 0, SD, O_DATA,  5, 0, 0);
    vec(0, 1, 0, 0, 0, 0, SF, O_ADV,   6, 0, 0);
    vec(0, 1, 0, 0, 0, 0, SD, O_DATA,  7, 0, 0);
    vec(0, 1, 1, 0, 0, 0, SF, O_LU,    8, 0, 0);  // load-use stall
    vec(0, 1, 0, 0, 0, 0, SD, O_DATA,  9, 1, 0);
    vec(0, 1, 1, 1, 0, 0, SF, O_BR,   10, 1, 0);  // branch beats load-use
    vec(0, 0, 0, 0, 0, 0, SD, O_DATA, 11, 1, 1);  // DATA wait x3
    vec(0, 0, 1, 1, 1, 0, SD, O_DATA, 12, 1, 1);
    vec(0, 0, 0, 0, 0, 0, SD, O_DATA, 13, 1, 1);
    vec(0, 1, 0, 0, 0, 0, SD, O_DATA, 14, 1, 1);
    vec(0, 1, 0, 0, 1, 0, SF, O_NONE, 15, 1, 1);  // halt request
    vec(0, 0, 0, 0, 0, 0, SH, O_NONE, 16, 1, 1);
    vec(0, 1, 1, 1, 1, 0, SH, O_NONE, 16, 1, 1);
    vec(0, 1, 0, 0, 0, 0, SH, O_NONE, 16, 1, 1);
    vec(0, 0, 0, 0, 0, 0, SH, O_NONE, 16, 1, 1);
    vec(0, 0, 0, 0, 0, 0, SH, O_NONE, 16, 1, 1);
    vec(0, 0, 0, 0, 0, 1, SH, O_NONE, 16, 1, 1);  // resume
    vec(0, 0, 0, 0, 0, 1, SF, O_NONE, 16, 1, 1);  // FETCH wait, resume ignored
    vec(0, 1, 0, 1, 0, 0, SF, O_BR,   17, 1, 1);
    vec(0, 0, 0, 0, 0, 0, SD, O_DATA, 18, 1, 2);
    vec(1, 0, 0, 0, 0, 0, SF, O_NONE,  0, 0, 0);  // async reset mid-DATA
    vec(1, 1, 0, 0, 0, 0, SF, O_NONE,  0, 0, 0);
    vec(0, 1, 0, 0, 1, 0, SF, O_NONE,  0, 0, 0);
    vec(0, 0, 0, 0, 0, 0, SH, O_NONE,  1, 0, 0);
    vec(0, 0, 0, 0, 0, 1, SH, O_NONE,  1, 0, 0);
    vec(0, 1, 0, 0, 0, 0, SF, O_ADV,   1, 0, 0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    n_checks++;
    if (sb.size() != 0 || n_pop != n_push) begin
      n_fail++;
      $display("FAIL drain: popped %0d expected %0d", n_pop, n_push);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
